// File: rtl/hex_entry_register_writer_pkg.sv
// Shared constants and types for the front-panel hex entry register writer.
package hex_entry_register_writer_pkg;

  // Index of each pushbutton in the debouncer array
  localparam int unsigned KEY_ENTER  = 0;
  localparam int unsigned KEY_COMMIT = 1;
  localparam int unsigned KEY_CLEAR  = 2;
  localparam int unsigned NUM_KEYS   = 3;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned REG_W    = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/hex_entry_register_writer_key_debouncer.sv
// One pushbutton: 2-flop synchronizer, stable-level debouncer, press pulse.
// A key that is already held when reset releases is tracked silently until it
// has been seen released once, so holding a key through reset cannot fire.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1, sync_2;
  logic             level;      // synchronized, active-high pressed
  logic             state;      // debounced level
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fill;       // synchronizer holds real samples once fill[1]
  logic             armed;

  assign level = ~sync_2;

  // Synchronize, count stable disagreement, flip state after a full window
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1      <= 1'b1;
      sync_2      <= 1'b1;
      state       <= 1'b0;
      cnt         <= '0;
      fill        <= 2'b00;
      armed       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync_1      <= key_n;
      sync_2      <= sync_1;
      fill        <= {fill[0], 1'b1};
      press_pulse <= 1'b0;
      if (fill[1] && !level)
        armed <= 1'b1;
      if (level == state) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        state       <= level;
        cnt         <= '0;
        press_pulse <= level & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_entry_register_writer.sv
// Front-panel writer: debounced keys shift hex digits into an entry buffer
// and commit the buffer into one of four display registers.
module hex_entry_register_writer
  import hex_entry_register_writer_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          CNT_W           = 19,
  parameter logic [15:0] REG_RESET_VALUE = 16'h0000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [3:0]  digit_in,
  input  logic        key_enter_n,
  input  logic        key_commit_n,
  input  logic        key_clear_n,
  input  logic [1:0]  register_selection,
  output logic [15:0] register_0,
  output logic [15:0] register_1,
  output logic [15:0] register_2,
  output logic [15:0] register_3,
  output logic [15:0] entry_value,
  output logic [2:0]  entry_count,
  output logic        write_strobe,
  output logic [1:0]  write_index
);

  logic [NUM_KEYS-1:0]             key_n;
  logic [NUM_KEYS-1:0]             press;
  logic [NUM_REGS-1:0][REG_W-1:0]  regs_q;
  logic                            ev_clear, ev_commit, ev_enter, do_write;
  wr_state_e                       state_q, state_d;

  assign key_n[KEY_ENTER]  = key_enter_n;
  assign key_n[KEY_COMMIT] = key_commit_n;
  assign key_n[KEY_CLEAR]  = key_clear_n;

  generate
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_deb (
        .clk        (clk_clk),
        .rst        (reset_reset),
        .key_n      (key_n[g]),
        .press_pulse(press[g])
      );
    end
  endgenerate

  // Priority clear > commit > enter; losers are dropped
  assign ev_clear  = press[KEY_CLEAR];
  assign ev_commit = press[KEY_COMMIT] & ~ev_clear;
  assign ev_enter  = press[KEY_ENTER] & ~ev_clear & ~press[KEY_COMMIT];
  assign do_write  = ev_commit && (entry_count != 3'd0);

  // FSM state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next state: a real commit enters WRITE for one cycle from either state
  always_comb begin
    state_d = IDLE;
    if (do_write) state_d = WRITE;
  end

  // Output decode: strobe coincides with the first cycle of the new value
  always_comb begin
    write_strobe = 1'b0;
    if (state_q == WRITE) write_strobe = 1'b1;
  end

  // Entry buffer, register file and last-written index
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET_VALUE;
      entry_value <= '0;
      entry_count <= '0;
      write_index <= '0;
    end else if (ev_clear) begin
      entry_value <= '0;
      entry_count <= '0;
    end else if (do_write) begin
      regs_q[register_selection] <= entry_value;
      write_index                <= register_selection;
      entry_value                <= '0;
      entry_count                <= '0;
    end else if (ev_enter) begin
      entry_value <= {entry_value[REG_W-5:0], digit_in};
      if (entry_count != 3'(DIGITS)) entry_count <= entry_count + 3'd1;
    end
  end

  assign register_0 = regs_q[0];
  assign register_1 = regs_q[1];
  assign register_2 = regs_q[2];
  assign register_3 = regs_q[3];

endmodule

// File: tb/tb_hex_entry_register_writer.sv
// Scenario bench: register writes are predicted into a queue and checked
// whenever write_strobe appears.
module tb_hex_entry_register_writer;

  localparam int D    = 4;
  localparam int HOLD = D + 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [3:0]  digit_in;
  logic        key_enter_n, key_commit_n, key_clear_n;
  logic [1:0]  register_selection;
  logic [15:0] register_0, register_1, register_2, register_3;
  logic [15:0] entry_value;
  logic [2:0]  entry_count;
  logic        write_strobe;
  logic [1:0]  write_index;

  hex_entry_register_writer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .REG_RESET_VALUE(16'h0000)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .digit_in          (digit_in),
    .key_enter_n       (key_enter_n),
    .key_commit_n      (key_commit_n),
    .key_clear_n       (key_clear_n),
    .register_selection(register_selection),
    .register_0        (register_0),
    .register_1        (register_1),
    .register_2        (register_2),
    .register_3        (register_3),
    .entry_value       (entry_value),
    .entry_count       (entry_count),
    .write_strobe      (write_strobe),
    .write_index       (write_index)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] val;
  } wr_t;

  wr_t         exp_q[$];
  int          total   = 0;
  int          passed  = 0;
  int          strobes = 0;
  logic        prev_strobe = 1'b0;
  logic [15:0] regs [4];

  assign regs[0] = register_0;
  assign regs[1] = register_1;
  assign regs[2] = register_2;
  assign regs[3] = register_3;

  // Scoreboard: every strobe must match the oldest predicted write
  always @(negedge clk_clk) begin
    wr_t e;
    if (write_strobe === 1'b1) begin
      strobes++;
      total++;
      if (prev_strobe) $display("FAIL strobe_width: strobe high two cycles in a row");
      else passed++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: idx %0d val %h, none expected", write_index, regs[write_index]);
      end else begin
        e = exp_q.pop_front();
        if (write_index !== e.idx || regs[e.idx] !== e.val)
          $display("FAIL write_check: got idx %0d val %h, want idx %0d val %h",
                   write_index, regs[e.idx], e.idx, e.val);
        else passed++;
      end
    end
    prev_strobe <= write_strobe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_enter_n  = v;
      1:       key_commit_n = v;
      default: key_clear_n  = v;
    endcase
  endtask

  task automatic press(input int k, input logic [3:0] d);
    digit_in = d;
    set_key(k, 1'b0);
    tick(HOLD);
    set_key(k, 1'b1);
    tick(HOLD);
  endtask

  task automatic test_reset;
    reset_reset = 1'b1;
    tick(3);
    reset_reset = 1'b0;
    tick(1);
    total++;
    if (entry_count !== 3'd0 || entry_value !== 16'h0 || write_strobe !== 1'b0 || write_index !== 2'd0)
      $display("FAIL por_state: cnt %0d entry %h strobe %b idx %0d, want all 0",
               entry_count, entry_value, write_strobe, write_index);
    else passed++;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      register_selection = 2'(i);
      press(0, 4'(i + 1));
      exp_q.push_back('{idx: 2'(i), val: 16'(i + 1)});
      press(1, 4'h0);
    end
    press(0, 4'h9);
    reset_reset = 1'b1;
    tick(1);
    reset_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (regs[i] !== 16'h0) $display("FAIL reset_reg%0d: got %h want 0000", i, regs[i]);
      else passed++;
    end
    total++;
    if (entry_count !== 3'd0 || entry_value !== 16'h0 || write_strobe !== 1'b0)
      $display("FAIL reset_entry: cnt %0d entry %h strobe %b, want 0", entry_count, entry_value, write_strobe);
    else passed++;
    tick(4);
  endtask

  task automatic test_commit_basic;
    int n = 0;
    int s0;
    register_selection = 2'd2;
    digit_in = 4'h1;
    key_enter_n = 1'b0;
    while (entry_count == 3'd0 && n < 20) begin
      tick(1);
      n++;
    end
    total++;
    if (n !== 3 + D) $display("FAIL enter_latency: got %0d edges want %0d", n, 3 + D);
    else passed++;
    tick(HOLD - n);
    key_enter_n = 1'b1;
    tick(HOLD);
    press(0, 4'h2);
    press(0, 4'h3);
    press(0, 4'h4);
    total++;
    if (entry_value !== 16'h1234 || entry_count !== 3'd4)
      $display("FAIL entry_1234: got %h/%0d want 1234/4", entry_value, entry_count);
    else passed++;
    s0 = strobes;
    exp_q.push_back('{idx: 2'd2, val: 16'h1234});
    press(1, 4'h0);
    total++;
    if (strobes !== s0 + 1) $display("FAIL commit_strobes: got %0d want %0d", strobes - s0, 1);
    else passed++;
    total++;
    if (register_2 !== 16'h1234 || write_index !== 2'd2 || entry_count !== 3'd0 || entry_value !== 16'h0)
      $display("FAIL commit_state: reg2 %h idx %0d cnt %0d entry %h", register_2, write_index, entry_count, entry_value);
    else passed++;
    total++;
    if (register_0 !== 16'h0 || register_1 !== 16'h0 || register_3 !== 16'h0)
      $display("FAIL commit_others: %h %h %h want 0", register_0, register_1, register_3);
    else passed++;
  endtask

  task automatic test_overflow;
    press(0, 4'hA);
    press(0, 4'hB);
    press(0, 4'hC);
    press(0, 4'hD);
    press(0, 4'hE);
    total++;
    if (entry_value !== 16'hBCDE || entry_count !== 3'd4)
      $display("FAIL overflow_entry: got %h/%0d want BCDE/4", entry_value, entry_count);
    else passed++;
    register_selection = 2'd0;
    exp_q.push_back('{idx: 2'd0, val: 16'hBCDE});
    press(1, 4'h0);
    register_selection = 2'd1;
    tick(2);
    total++;
    if (register_0 !== 16'hBCDE || register_1 !== 16'h0 || register_2 !== 16'h1234)
      $display("FAIL overflow_regs: %h %h %h", register_0, register_1, register_2);
    else passed++;
  endtask

  task automatic test_glitch;
    digit_in = 4'h9;
    key_enter_n = 1'b0;
    tick(3);
    key_enter_n = 1'b1;
    tick(20);
    total++;
    if (entry_count !== 3'd0) $display("FAIL glitch_count: got %0d want 0", entry_count);
    else passed++;
    key_enter_n = 1'b0;
    tick(100);
    key_enter_n = 1'b1;
    tick(HOLD);
    total++;
    if (entry_count !== 3'd1 || entry_value !== 16'h0009)
      $display("FAIL hold_once: got %h/%0d want 0009/1", entry_value, entry_count);
    else passed++;
    press(2, 4'h0);
    total++;
    if (entry_count !== 3'd0 || entry_value !== 16'h0 || register_0 !== 16'hBCDE)
      $display("FAIL clear_only: got %h/%0d reg0 %h", entry_value, entry_count, register_0);
    else passed++;
  endtask

  task automatic test_clear_commit;
    int s0;
    press(0, 4'h7);
    press(0, 4'h7);
    total++;
    if (entry_value !== 16'h0077) $display("FAIL entry_0077: got %h want 0077", entry_value);
    else passed++;
    s0 = strobes;
    key_commit_n = 1'b0;
    key_clear_n  = 1'b0;
    tick(HOLD);
    key_commit_n = 1'b1;
    key_clear_n  = 1'b1;
    tick(HOLD);
    total++;
    if (entry_count !== 3'd0 || entry_value !== 16'h0 || strobes !== s0)
      $display("FAIL clear_beats_commit: cnt %0d entry %h strobes %0d", entry_count, entry_value, strobes - s0);
    else passed++;
    total++;
    if (register_0 !== 16'hBCDE || register_1 !== 16'h0 || register_2 !== 16'h1234 || register_3 !== 16'h0)
      $display("FAIL clear_regs: %h %h %h %h", register_0, register_1, register_2, register_3);
    else passed++;
    press(1, 4'h0);
    total++;
    if (strobes !== s0 || register_1 !== 16'h0)
      $display("FAIL empty_commit: strobes %0d reg1 %h want 0/0000", strobes - s0, register_1);
    else passed++;
  endtask

  task automatic test_partial;
    press(0, 4'hA);
    press(0, 4'h5);
    register_selection = 2'd3;
    exp_q.push_back('{idx: 2'd3, val: 16'h00A5});
    press(1, 4'h0);
    total++;
    if (register_3 !== 16'h00A5 || write_index !== 2'd3)
      $display("FAIL partial: reg3 %h idx %0d want 00A5/3", register_3, write_index);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int s0;
    digit_in = 4'h6;
    key_enter_n = 1'b0;
    tick(4);
    reset_reset = 1'b1;
    tick(2);
    reset_reset = 1'b0;
    s0 = strobes;
    tick(30);
    total++;
    if (entry_count !== 3'd0 || strobes !== s0 || register_3 !== 16'h0 || register_2 !== 16'h0)
      $display("FAIL reset_mid: cnt %0d strobes %0d reg3 %h reg2 %h", entry_count, strobes - s0, register_3, register_2);
    else passed++;
    key_enter_n = 1'b1;
    tick(HOLD);
    press(0, 4'h3);
    total++;
    if (entry_count !== 3'd1 || entry_value !== 16'h0003)
      $display("FAIL repress: got %h/%0d want 0003/1", entry_value, entry_count);
    else passed++;
  endtask

  initial begin
    reset_reset        = 1'b1;
    digit_in           = 4'h0;
    key_enter_n        = 1'b1;
    key_commit_n       = 1'b1;
    key_clear_n        = 1'b1;
    register_selection = 2'd0;
    test_reset();
    test_commit_basic();
    test_overflow();
    test_glitch();
    test_clear_commit();
    test_partial();
    test_reset_mid();
    tick(2);
    total++;
    if (exp_q.size() != 0) $display("FAIL pending_writes: %0d never seen", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
